// File: rtl/dmem_mmio.sv
// Data memory with a small MMIO window: TX FIFO, STATUS and a free-running CYCLE counter.
// Optional store alignment check is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_mmio #(
  parameter int DEPTH      = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [31:0] TxData,
  output logic        TxValid,
  input  logic        TxReady
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [4:0] FULL_COUNT = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    REG_TXDATA = 2'd0,
    REG_STATUS = 2'd1,
    REG_CYCLE  = 2'd2,
    REG_RSVD   = 2'd3
  } mmio_reg_e;

  logic            isMmio;
  mmio_reg_e       regSel;
  logic [AW-1:0]   ramIdx;
  logic            wrMisaligned;
  logic            wrAccept;
  logic            ramWe;
  logic            txPush;
  logic            statusWr;
  logic            cycleWr;
  logic            unusedAddr;

  assign isMmio = ALUResult[31];
  assign regSel = mmio_reg_e'(ALUResult[3:2]);
  assign ramIdx = ALUResult[AW+1:2];

  // Address bits that never take part in any decode.
  assign unusedAddr = ^{ALUResult[30:AW+2], ALUResult[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
  assign wrMisaligned = MemWrite & (ALUResult[1:0] != 2'b00);
`else
  assign wrMisaligned = 1'b0;
`endif

  assign wrAccept = MemWrite & ~wrMisaligned;
  assign ramWe    = wrAccept & ~isMmio;
  assign txPush   = wrAccept & isMmio & (regSel == REG_TXDATA);
  assign statusWr = wrAccept & isMmio & (regSel == REG_STATUS);
  assign cycleWr  = wrAccept & isMmio & (regSel == REG_CYCLE);

  // Word RAM: synchronous write, asynchronous read, never cleared by reset.
  logic [31:0] ram_q [DEPTH];

  always_ff @(posedge clk) begin
    if (ramWe) begin
      ram_q[ramIdx] <= WriteData;
    end
  end

  logic [31:0]   fifo_q [FIFO_DEPTH];
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [4:0]    count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [31:0]   cycle_q, cycle_d;
  logic          empty;
  logic          full;
  logic          pop;
  logic          doPush;
  logic          overflowSet;
  logic          misalign;

  assign empty       = (count_q == 5'd0);
  assign full        = (count_q == FULL_COUNT);
  assign TxValid     = ~empty;
  assign TxData      = empty ? 32'd0 : fifo_q[rdPtr_q];
  assign pop         = TxValid & TxReady;
  // A push into a full FIFO still fits when the head leaves on the same edge.
  assign doPush      = txPush & (~full | pop);
  assign overflowSet = txPush & full & ~pop;

  always_ff @(posedge clk) begin
    if (doPush) begin
      fifo_q[wrPtr_q] <= WriteData;
    end
  end

  always_comb begin
    rdPtr_d    = rdPtr_q;
    wrPtr_d    = wrPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (pop) begin
      rdPtr_d = rdPtr_q + PW'(1);
    end
    if (doPush) begin
      wrPtr_d = wrPtr_q + PW'(1);
    end
    case ({doPush, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
    if (overflowSet) begin
      overflow_d = 1'b1;
    end else if (statusWr) begin
      overflow_d = 1'b0;
    end
  end

  always_comb begin
    cycle_d = cycleWr ? WriteData : cycle_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      cycle_q    <= '0;
    end else begin
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      cycle_q    <= cycle_d;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  // A rejected store wins over a simultaneous clear attempt.
  always_comb begin
    misalign_d = misalign_q;
    if (wrMisaligned) begin
      misalign_d = 1'b1;
    end else if (statusWr) begin
      misalign_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

  // STATUS: [8] misalign, [7] overflow, [6:2] count, [1] full, [0] empty.
  logic [31:0] statusWord;
  assign statusWord = {23'd0, misalign, overflow_q, count_q, full, empty};

  always_comb begin
    ReadData = '0;
    if (!isMmio) begin
      ReadData = ram_q[ramIdx];
    end else begin
      case (regSel)
        REG_STATUS: ReadData = statusWord;
        REG_CYCLE:  ReadData = cycle_q;
        default:    ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Bench for dmem_mmio: directed literal checks plus randomized traffic against a queue-based model.
module tb_dmem_mmio;

  localparam int DEPTH      = 64;
  localparam int FIFO_DEPTH = 4;
  localparam logic [31:0] A_TX     = 32'h8000_0000;
  localparam logic [31:0] A_STATUS = 32'h8000_0004;
  localparam logic [31:0] A_CYCLE  = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] ALUResult = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic [31:0] TxData;
  logic        TxValid;
  logic        TxReady = 1'b0;

  int errors = 0;
  int checks = 0;

  dmem_mmio #(.DEPTH(DEPTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .MemWrite(MemWrite),
    .ALUResult(ALUResult),
    .WriteData(WriteData),
    .ReadData(ReadData),
    .TxData(TxData),
    .TxValid(TxValid),
    .TxReady(TxReady)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [31:0] a, input logic [31:0] d, input logic rdy);
    MemWrite  = we;
    ALUResult = a;
    WriteData = d;
    TxReady   = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain arrays, a word queue and sticky flags.
  logic [31:0] mRam [DEPTH];
  bit          mValid [DEPTH];
  logic [31:0] mq [$];
  logic        mOvf = 1'b0;
  logic        mMis = 1'b0;
  logic [31:0] mCycle = '0;

  logic [31:0] cExp;
  logic        cKnown;
  int          cIdx;
  int          cSz;
  logic        cPop;
  logic        cMis;
  logic        cAcc;

  always @(negedge clk) begin
    if (!reset) begin
      mq.delete();
      mOvf   = 1'b0;
      mMis   = 1'b0;
      mCycle = '0;
    end
    cSz    = mq.size();
    cKnown = 1'b1;
    cExp   = '0;
    cIdx   = int'((ALUResult >> 2) % DEPTH);
    if (ALUResult[31]) begin
      case (ALUResult[3:2])
        2'd1: cExp = 32'(cSz == 0) | (32'(cSz == FIFO_DEPTH) << 1) | (32'(cSz) << 2)
                     | (32'(mOvf) << 7) | (32'(mMis) << 8);
        2'd2: cExp = mCycle;
        default: cExp = '0;
      endcase
    end else begin
      cKnown = mValid[cIdx];
      cExp   = mRam[cIdx];
    end
    if (cKnown) checkOutput("model_rdata", ReadData, cExp);
    checkOutput("model_txvalid", {31'd0, TxValid}, {31'd0, cSz != 0});
    checkOutput("model_txdata", TxData, (cSz != 0) ? mq[0] : 32'd0);

    if (reset) begin
`ifdef DMEM_ALIGN_CHECK_EN
      cMis = MemWrite && (ALUResult[1:0] != 2'b00);
`else
      cMis = 1'b0;
`endif
      cAcc = MemWrite && !cMis;
      cPop = (cSz != 0) && TxReady;
      if (cMis) mMis = 1'b1;
      if (cAcc && !ALUResult[31]) begin
        mRam[cIdx]   = WriteData;
        mValid[cIdx] = 1'b1;
      end
      if (cPop) void'(mq.pop_front());
      if (cAcc && ALUResult[31] && ALUResult[3:2] == 2'd0) begin
        if (cSz < FIFO_DEPTH || cPop) mq.push_back(WriteData);
        else mOvf = 1'b1;
      end
      if (cAcc && ALUResult[31] && ALUResult[3:2] == 2'd1) begin
        mOvf = 1'b0;
        mMis = 1'b0;
      end
      mCycle = (cAcc && ALUResult[31] && ALUResult[3:2] == 2'd2) ? WriteData : mCycle + 32'd1;
    end
  end

  logic [31:0] drainA [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
  logic [31:0] drainB [4] = '{32'hA2, 32'hA3, 32'hA4, 32'h66};
  logic [31:0] ra;

  initial begin
    tick();
    tick();
    tick();
    applyStimulus(1'b0, A_STATUS, '0, 1'b0);
    checkOutput("rst_status", ReadData, 32'h1);
    checkOutput("rst_txvalid", {31'd0, TxValid}, 32'd0);
    checkOutput("rst_txdata", TxData, 32'd0);
    reset = 1'b1;
    applyStimulus(1'b0, A_CYCLE, '0, 1'b0);
    tick();
    tick();
    checkOutput("cycle_after_release", ReadData, 32'd2);

    applyStimulus(1'b1, 32'h10, 32'h1234_5678, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
    checkOutput("ram_same_cycle_old", ReadData, 32'h1234_5678);
    tick();
    applyStimulus(1'b0, 32'h10, '0, 1'b0);
    checkOutput("ram_read", ReadData, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 32'h110, '0, 1'b0);
    checkOutput("ram_alias", ReadData, 32'hDEAD_BEEF);

    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b1, A_TX, 32'h11 * k, 1'b0);
      tick();
    end
    applyStimulus(1'b0, A_STATUS, '0, 1'b0);
    checkOutput("status_full_ovf", ReadData, 32'h92);
    checkOutput("head_first", TxData, 32'h11);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, A_STATUS, '0, 1'b1);
      checkOutput("drain_a", TxData, drainA[k]);
      tick();
    end
    applyStimulus(1'b0, A_STATUS, '0, 1'b0);
    checkOutput("drained_txvalid", {31'd0, TxValid}, 32'd0);
    checkOutput("drained_txdata", TxData, 32'd0);
    checkOutput("status_ovf_sticky", ReadData, 32'h81);

    applyStimulus(1'b1, A_STATUS, '0, 1'b0);
    tick();
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, A_TX, 32'hA0 + k, 1'b0);
      tick();
    end
    applyStimulus(1'b1, A_TX, 32'h66, 1'b1);
    tick();
    applyStimulus(1'b0, A_STATUS, '0, 1'b0);
    checkOutput("status_push_pop_full", ReadData, 32'h12);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, A_STATUS, '0, 1'b1);
      checkOutput("drain_b", TxData, drainB[k]);
      tick();
    end
    applyStimulus(1'b0, A_STATUS, '0, 1'b0);
    checkOutput("drain_b_empty", ReadData, 32'h1);

    applyStimulus(1'b1, A_CYCLE, 32'hFFFF_FFFE, 1'b0);
    tick();
    applyStimulus(1'b0, A_CYCLE, '0, 1'b0);
    checkOutput("cycle_loaded", ReadData, 32'hFFFF_FFFE);
    tick();
    checkOutput("cycle_max", ReadData, 32'hFFFF_FFFF);
    tick();
    checkOutput("cycle_wrap", ReadData, 32'h0);

    applyStimulus(1'b1, 32'h20, 32'h1111_1111, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h22, 32'hAAAA_5555, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h22, '0, 1'b0);
`ifdef DMEM_ALIGN_CHECK_EN
    checkOutput("misaligned_store_blocked", ReadData, 32'h1111_1111);
    applyStimulus(1'b0, A_STATUS, '0, 1'b0);
    checkOutput("misalign_flag", ReadData, 32'h101);
    applyStimulus(1'b1, A_STATUS, '0, 1'b0);
    tick();
    applyStimulus(1'b0, A_STATUS, '0, 1'b0);
    checkOutput("misalign_cleared", ReadData, 32'h1);
`else
    checkOutput("unaligned_store_writes", ReadData, 32'hAAAA_5555);
    applyStimulus(1'b0, A_STATUS, '0, 1'b0);
    checkOutput("no_misalign_flag", ReadData, 32'h1);
`endif

    applyStimulus(1'b1, A_TX, 32'h77, 1'b0);
    tick();
    applyStimulus(1'b0, A_STATUS, '0, 1'b0);
    checkOutput("pre_reset_valid", {31'd0, TxValid}, 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("midreset_txvalid", {31'd0, TxValid}, 32'd0);
    checkOutput("midreset_txdata", TxData, 32'd0);
    checkOutput("midreset_status", ReadData, 32'h1);
    tick();
    reset = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b0;
        tick();
        reset = 1'b1;
      end
      if ($urandom_range(0, 1) == 0) begin
        ra = $urandom & 32'h7FFF_FF3F;
      end else begin
        ra = A_TX | ($urandom & 32'h7FFF_FFFF);
      end
      if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
      applyStimulus(1'($urandom_range(0, 1)), ra, $urandom, 1'($urandom_range(0, 1)));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
